// File: rtl/imem_loader.sv
// Boot-time instruction-memory loader: length-prefixed byte stream -> little-endian 32-bit words.
// Define IMEM_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte after the instruction bytes.
module imem_loader #(
  parameter int unsigned ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  byte_valid,
  input  logic [7:0]            byte_data,
  output logic                  byte_ready,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]           imem_wdata,
  output logic                  core_reset,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [ADDR_WIDTH:0]   word_count
);

  localparam int unsigned MAX_WORDS = 2 ** ADDR_WIDTH;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_LO,
    S_LEN_HI,
    S_DATA,
    S_DONE,
    S_ERROR
`ifdef IMEM_LOADER_CHECKSUM_EN
    , S_CHECK
`endif
  } state_e;

  state_e                state_q, state_d;
  logic [15:0]           len_q, len_d;
  logic [1:0]            bcnt_q, bcnt_d;
  logic [23:0]           shift_q, shift_d;
  logic [ADDR_WIDTH:0]   wcnt_q, wcnt_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic                  crst_q, crst_d;
  logic                  busy_w;
  logic                  accept;
  logic [15:0]           n_full;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]            csum_q, csum_d;
`endif

  always_comb begin
    busy_w = (state_q == S_LEN_LO) || (state_q == S_LEN_HI) || (state_q == S_DATA)
`ifdef IMEM_LOADER_CHECKSUM_EN
             || (state_q == S_CHECK)
`endif
             ;
  end

  assign accept = byte_valid && busy_w;
  assign n_full = {byte_data, len_q[7:0]};

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    bcnt_d  = bcnt_q;
    shift_d = shift_q;
    wcnt_d  = wcnt_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    csum_d  = csum_q;
`endif
    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) begin
          state_d = S_LEN_LO;
          wcnt_d  = '0;
          bcnt_d  = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
          csum_d  = '0;
`endif
        end
      end
      S_LEN_LO: begin
        if (accept) begin
          len_d   = {8'h00, byte_data};
          state_d = S_LEN_HI;
        end
      end
      S_LEN_HI: begin
        if (accept) begin
          len_d = n_full;
          if (32'(n_full) > MAX_WORDS) begin
            state_d = S_ERROR;
          end else if (n_full == 16'h0000) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            state_d = S_CHECK;
`else
            state_d = S_DONE;
`endif
          end else begin
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (accept) begin
          bcnt_d  = bcnt_q + 2'd1;
          shift_d = {byte_data, shift_q[23:8]};
`ifdef IMEM_LOADER_CHECKSUM_EN
          csum_d  = csum_q ^ byte_data;
`endif
          if (bcnt_q == 2'd3) begin
            we_d    = 1'b1;
            addr_d  = wcnt_q[ADDR_WIDTH-1:0];
            wdata_d = {byte_data, shift_q};
            wcnt_d  = wcnt_q + (ADDR_WIDTH+1)'(1);
            if (32'(wcnt_q) + 32'd1 == 32'(len_q)) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
              state_d = S_CHECK;
`else
              state_d = S_DONE;
`endif
            end
          end
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CHECK: begin
        if (accept) begin
          state_d = (byte_data == csum_q) ? S_DONE : S_ERROR;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
    // Release the core only once DONE has been held for a full cycle, so the last write lands first.
    crst_d = !((state_q == S_DONE) && (state_d == S_DONE));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      bcnt_q  <= '0;
      shift_q <= '0;
      wcnt_q  <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      crst_q  <= 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      bcnt_q  <= bcnt_d;
      shift_q <= shift_d;
      wcnt_q  <= wcnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      crst_q  <= crst_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q  <= csum_d;
`endif
    end
  end

  assign byte_ready = busy_w;
  assign busy       = busy_w;
  assign done       = (state_q == S_DONE);
  assign error      = (state_q == S_ERROR);
  assign imem_we    = we_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign core_reset = crst_q;
  assign word_count = wcnt_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: per-cycle vector table plus a write-spacing sequence.
module tb_imem_loader;

  localparam int unsigned AW = 8;

  typedef logic [AW:0] wc_t;
  typedef enum {P_IDLE, P_BUSY, P_DONE1, P_DONE, P_ERR} ph_e;
  typedef struct {
    bit          rs;
    bit          st;
    bit          v;
    logic [7:0]  d;
    ph_e         ph;
    bit          we;
    bit          aw;
    logic [AW-1:0] addr;
    logic [31:0] wd;
    wc_t         wc;
  } vec_t;

`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam ph_e FIN = P_BUSY;
`else
  localparam ph_e FIN = P_DONE1;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          byte_valid = 1'b0;
  logic [7:0]    byte_data = 8'h00;
  logic          byte_ready, imem_we, core_reset, busy, done, error;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  wc_t           word_count;

  vec_t tbl[$];
  int   pass_cnt = 0;
  int   total = 0;

  imem_loader #(.ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset(reset), .start(start), .byte_valid(byte_valid), .byte_data(byte_data),
    .byte_ready(byte_ready), .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .core_reset(core_reset), .busy(busy), .done(done), .error(error), .word_count(word_count)
  );

  always #5 clk = ~clk;

  task automatic add(input bit st, input bit v, input logic [7:0] d, input ph_e ph, input wc_t wc);
    vec_t e;
    e.rs = 1'b0; e.st = st; e.v = v; e.d = d; e.ph = ph;
    e.we = 1'b0; e.aw = 1'b0; e.addr = '0; e.wd = '0; e.wc = wc;
    tbl.push_back(e);
  endtask

  task automatic add_rst();
    vec_t e;
    e.rs = 1'b1; e.st = 1'b0; e.v = 1'b0; e.d = 8'h00; e.ph = P_IDLE;
    e.we = 1'b0; e.aw = 1'b1; e.addr = '0; e.wd = '0; e.wc = '0;
    tbl.push_back(e);
  endtask

  task automatic add_stalls(input int unsigned n, input wc_t wc);
    for (int unsigned k = 0; k < n; k++) add(1'b0, 1'b0, 8'h5A, P_BUSY, wc);
  endtask

  // One word, LSB first; 'gap' idle cycles after each of the first three bytes.
  task automatic add_word(input logic [31:0] w, input logic [AW-1:0] a, input int unsigned gap,
                          input bit st0, input ph_e last);
    vec_t e;
    for (int unsigned b = 0; b < 3; b++) begin
      add((b == 0) ? st0 : 1'b0, 1'b1, w[8*b +: 8], P_BUSY, wc_t'(a));
      add_stalls(gap, wc_t'(a));
    end
    e.rs = 1'b0; e.st = 1'b0; e.v = 1'b1; e.d = w[31:24]; e.ph = last;
    e.we = 1'b1; e.aw = 1'b1; e.addr = a; e.wd = w; e.wc = wc_t'(a) + wc_t'(1);
    tbl.push_back(e);
  endtask

  task automatic check(input string nm, input vec_t e);
    logic e_rdy, e_done, e_err, e_crst;
    bit   ok;
    e_rdy  = (e.ph == P_BUSY);
    e_done = (e.ph == P_DONE1) || (e.ph == P_DONE);
    e_err  = (e.ph == P_ERR);
    e_crst = (e.ph != P_DONE);
    ok = (byte_ready === e_rdy) && (busy === e_rdy) && (done === e_done) && (error === e_err) &&
         (core_reset === e_crst) && (imem_we === e.we) && (word_count === e.wc);
    if (e.aw) ok = ok && (imem_addr === e.addr) && (imem_wdata === e.wd);
    total++;
    if (ok) pass_cnt++;
    else $display("FAIL %s: got rdy=%b busy=%b done=%b err=%b crst=%b we=%b wc=%0d addr=%0h wd=%h; expected rdy=%b busy=%b done=%b err=%b crst=%b we=%b wc=%0d addr=%0h wd=%h (addr/wd checked=%b)",
                  nm, byte_ready, busy, done, error, core_reset, imem_we, word_count, imem_addr, imem_wdata,
                  e_rdy, e_rdy, e_done, e_err, e_crst, e.we, e.wc, e.addr, e.wd, e.aw);
  endtask

  initial begin
    logic [7:0]  hs[10];
    int          we_cyc[$];
    logic [31:0] we_dat[$];

    // Reset state
    add_rst();
    // 3-word load; start during an accepted DATA byte must be ignored
    add(1'b1, 1'b0, 8'h00, P_BUSY, 0);
    add(1'b0, 1'b1, 8'h03, P_BUSY, 0);
    add(1'b0, 1'b1, 8'h00, P_BUSY, 0);
    add_word(32'h00F00093, 8'd0, 0, 1'b0, P_BUSY);
    add_word(32'h0FF00113, 8'd1, 0, 1'b1, P_BUSY);
    add_word(32'h00000013, 8'd2, 0, 1'b0, FIN);
`ifdef IMEM_LOADER_CHECKSUM_EN
    add(1'b0, 1'b1, 8'h9D, P_DONE1, 3);
`endif
    add(1'b0, 1'b0, 8'h00, P_DONE, 3);
    add(1'b0, 1'b1, 8'h77, P_DONE, 3);
    // N = 0 (restart from DONE clears word_count and raises core_reset)
    add(1'b1, 1'b0, 8'h00, P_BUSY, 0);
    add(1'b0, 1'b1, 8'h00, P_BUSY, 0);
    add(1'b0, 1'b1, 8'h00, FIN, 0);
`ifdef IMEM_LOADER_CHECKSUM_EN
    add(1'b0, 1'b1, 8'h00, P_DONE1, 0);
`endif
    add(1'b0, 1'b0, 8'h00, P_DONE, 0);
    // Overflow N = 0x0101, then re-arm
    add(1'b1, 1'b0, 8'h00, P_BUSY, 0);
    add(1'b0, 1'b1, 8'h01, P_BUSY, 0);
    add(1'b0, 1'b1, 8'h01, P_ERR, 0);
    add(1'b0, 1'b1, 8'h55, P_ERR, 0);
    add(1'b0, 1'b0, 8'h00, P_ERR, 0);
    add(1'b1, 1'b0, 8'h00, P_BUSY, 0);
    // Stalled single-word load
    add(1'b0, 1'b1, 8'h01, P_BUSY, 0);
    add_stalls(3, 0);
    add(1'b0, 1'b1, 8'h00, P_BUSY, 0);
    add_stalls(3, 0);
    add_word(32'hDEADBEEF, 8'd0, 3, 1'b0, FIN);
`ifdef IMEM_LOADER_CHECKSUM_EN
    add(1'b0, 1'b1, 8'h22, P_DONE1, 1);
`endif
    add(1'b0, 1'b0, 8'h00, P_DONE, 1);
    // N = MAX_WORDS is legal
    add(1'b1, 1'b0, 8'h00, P_BUSY, 0);
    add(1'b0, 1'b1, 8'h00, P_BUSY, 0);
    add(1'b0, 1'b1, 8'h01, P_BUSY, 0);
    add(1'b0, 1'b1, 8'hAA, P_BUSY, 0);
    add_rst();
    // Reset after 6 data bytes, then a full 2-word reload
    add(1'b1, 1'b0, 8'h00, P_BUSY, 0);
    add(1'b0, 1'b1, 8'h02, P_BUSY, 0);
    add(1'b0, 1'b1, 8'h00, P_BUSY, 0);
    add_word(32'h12345678, 8'd0, 0, 1'b0, P_BUSY);
    add(1'b0, 1'b1, 8'h0D, P_BUSY, 1);
    add(1'b0, 1'b1, 8'hF0, P_BUSY, 1);
    add_rst();
    add(1'b1, 1'b0, 8'h00, P_BUSY, 0);
    add(1'b0, 1'b1, 8'h02, P_BUSY, 0);
    add(1'b0, 1'b1, 8'h00, P_BUSY, 0);
    add_word(32'h12345678, 8'd0, 0, 1'b0, P_BUSY);
    add_word(32'hCAFEF00D, 8'd1, 0, 1'b0, FIN);
`ifdef IMEM_LOADER_CHECKSUM_EN
    add(1'b0, 1'b1, 8'hC1, P_DONE1, 2);
`endif
    add(1'b0, 1'b0, 8'h00, P_DONE, 2);
`ifdef IMEM_LOADER_CHECKSUM_EN
    // Bad then good checksum
    add(1'b1, 1'b0, 8'h00, P_BUSY, 0);
    add(1'b0, 1'b1, 8'h01, P_BUSY, 0);
    add(1'b0, 1'b1, 8'h00, P_BUSY, 0);
    add_word(32'h11223344, 8'd0, 0, 1'b0, P_BUSY);
    add(1'b0, 1'b1, 8'h45, P_ERR, 1);
    add(1'b0, 1'b0, 8'h00, P_ERR, 1);
    add(1'b1, 1'b0, 8'h00, P_BUSY, 0);
    add(1'b0, 1'b1, 8'h01, P_BUSY, 0);
    add(1'b0, 1'b1, 8'h00, P_BUSY, 0);
    add_word(32'h11223344, 8'd0, 0, 1'b0, P_BUSY);
    add(1'b0, 1'b1, 8'h44, P_DONE1, 1);
    add(1'b0, 1'b0, 8'h00, P_DONE, 1);
`endif

    #1;
    foreach (tbl[i]) begin
      start      = tbl[i].st;
      byte_valid = tbl[i].v;
      byte_data  = tbl[i].d;
      if (tbl[i].rs) begin
        reset = 1'b0;
        #2;
        check($sformatf("vec%0d_async_reset", i), tbl[i]);
        @(posedge clk); #1;
        check($sformatf("vec%0d_reset_held", i), tbl[i]);
      end else begin
        reset = 1'b1;
        @(posedge clk); #1;
        check($sformatf("vec%0d", i), tbl[i]);
      end
    end

    // Back-to-back words: one write every 4 cycles, correct data
    hs = '{8'h02, 8'h00, 8'h44, 8'h33, 8'h22, 8'h11, 8'hDD, 8'hCC, 8'hBB, 8'hAA};
    start = 1'b1; byte_valid = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < 12; k++) begin
      byte_valid = (k < 10);
      byte_data  = (k < 10) ? hs[k] : 8'h00;
      @(posedge clk); #1;
      if (imem_we === 1'b1) begin
        we_cyc.push_back(k);
        we_dat.push_back(imem_wdata);
      end
    end
    total++;
    if (we_cyc.size() == 2) pass_cnt++;
    else $display("FAIL b2b_write_count: got %0d writes, expected 2", we_cyc.size());
    total++;
    if (we_cyc.size() == 2 && we_cyc[1] - we_cyc[0] == 4 && we_cyc[0] == 5) pass_cnt++;
    else $display("FAIL b2b_write_spacing: got write cycles %p, expected 5 and 9", we_cyc);
    total++;
    if (we_dat.size() == 2 && we_dat[0] === 32'h11223344 && we_dat[1] === 32'hAABBCCDD) pass_cnt++;
    else $display("FAIL b2b_write_data: got %p, expected 11223344 and aabbccdd", we_dat);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time instruction-memory writer for the pipelined processor. Receives a length-prefixed byte stream over a valid/ready interface and assembles little-endian 32-bit instruction words. Writes those words into instruction memory from word address 0 while holding the processor core in reset, then releases the core. It sits beside the fetch stage and drives the write port of the instruction memory that fetch reads.

## Interface
- ADDR_WIDTH, 8, word-address width of instruction memory; capacity MAX_WORDS = 2**ADDR_WIDTH
- clk  in  1  system clock, rising edge
- reset  in  1  active-low asynchronous reset
- start  in  1  one-cycle pulse; begins a load session from IDLE, DONE or ERROR
- byte_valid  in  1  source has a byte on byte_data
- byte_data  in  8  stream byte
- byte_ready  out  1  loader accepts a byte this cycle
- imem_we  out  1  instruction-memory write strobe, one cycle per word
- imem_addr  out  ADDR_WIDTH  word address of the write
- imem_wdata  out  32  assembled instruction word
- core_reset  out  1  active-high reset to the processor; high while not DONE
- busy  out  1  session in progress
- done  out  1  load completed successfully, sticky until start or reset
- error  out  1  load failed, sticky until start or reset
- word_count  out  ADDR_WIDTH+1  words written in the current session

## Operation
- Transfer: a byte is consumed on a rising edge where byte_valid && byte_ready.
- Stream format:
  - N_lo, N_hi: 16-bit word count N.
  - N×4 instruction bytes, least-significant byte first.
  - With the checksum feature enabled, one trailing checksum byte follows.
- States: IDLE, LEN_LO, LEN_HI, DATA, CHECK (macro only), DONE, ERROR.
- IDLE → LEN_LO on start.
- DONE/ERROR → LEN_LO on start. This clears done, error and word_count and raises core_reset.
- start is ignored in LEN_LO, LEN_HI, DATA and CHECK.
- LEN_LO → LEN_HI on the first byte.
- LEN_HI on the second byte:
  - N > MAX_WORDS → ERROR.
  - N == 0 → DONE, or CHECK with the macro enabled.
  - otherwise → DATA.
- DATA: a 2-bit byte counter shifts bytes into the word register.
  - On the 4th byte, the word is registered to imem_wdata, imem_addr = word_count, and imem_we is set.
  - word_count increments on that same edge.
  - After word N: → DONE, or CHECK with the macro enabled.
- byte_ready = 1 in LEN_LO, LEN_HI, DATA and CHECK. It is 0 in IDLE, DONE, ERROR and during reset.
- busy = 1 in LEN_LO, LEN_HI, DATA and CHECK.
- done = 1 in DONE; error = 1 in ERROR.
- core_reset = 0 only in DONE, one cycle after DONE is entered (see Timing).
- Reset values:
  - state IDLE
  - byte_ready 0, imem_we 0, imem_addr 0, imem_wdata 0
  - core_reset 1, busy 0, done 0, error 0, word_count 0
- Reset mid-session: the session is abandoned immediately. Already-written words stay in memory, and the next session rewrites them from address 0.
- Gaps in byte_valid stall the FSM with no state change and no timeout.

## Timing
- Write latency: imem_we is high in the cycle immediately after the edge that accepted a word's 4th byte, for exactly one cycle.
- Back-to-back words at one byte per cycle give one imem_we every 4 cycles.
- Completion:
  - DONE is entered on the edge accepting the final byte; done = 1 in the next cycle, concurrent with the last imem_we.
  - core_reset falls one edge later, so the last write completes before the processor leaves reset.
- ERROR is entered on the offending byte's edge. byte_ready drops in the next cycle; no further bytes are accepted and no imem_we is issued.
- start coinciding with an accepted byte in a busy state: start is ignored and the byte is processed normally.

## Configuration
- IMEM_LOADER_CHECKSUM_EN defined:
  - A running XOR of all N×4 instruction bytes is kept.
  - CHECK accepts one byte. If it equals the XOR → DONE; otherwise → ERROR, and core_reset stays high.
  - For N == 0 the expected checksum byte is 0x00.
- Undefined: the CHECK state, checksum register and trailing byte do not exist. The session ends after the last instruction byte.

## Test plan
- 3-word load: stream 03 00, then 0x00F00093, 0x0FF00113, 0x00000013, one byte per cycle → imem_we pulses at addr 0, 1, 2 with those words. done = 1; core_reset falls one cycle after the last imem_we; word_count = 3.
- N = 0: stream 00 00 → DONE after 2 bytes, no imem_we, core_reset falls. With the macro, a trailing 00 is required first.
- Overflow (ADDR_WIDTH = 8): N = 0x0101 → error = 1 after LEN_HI, byte_ready = 0, core_reset stays 1. A subsequent start re-arms the loader.
- Stalls: 1 word with byte_valid low for 3 cycles between each byte → identical single write, correct word, no spurious imem_we.
- Reset mid-load: assert reset after 6 data bytes → all outputs at reset values. A fresh start plus a full 2-word stream writes addr 0 and 1 correctly.
- Checksum (macro on): 1 word 0x11223344 with trailing 0x44 → DONE. With trailing 0x45 → ERROR after one imem_we at addr 0, and core_reset stays 1.
